la_capture_readout: RTL and testbench

- Read-side companion to the logic-analyzer capture core. Once capture has halted, it walks the 512-entry ring buffer in chronological order, beginning at the captured window start.
- Drives the core's read_addr and collects read_data.
- Serializes each sample into bytes on a valid/ready byte stream, framed by a header byte and an XOR checksum trailer.
- Sits between the capture core and the host link transmitter (e.g. the UART TX).

---
 rtl/la_capture_readout_if.sv | 28 ++
 rtl/la_capture_readout.sv | 159 +++++++++++++++
 tb/tb_la_capture_readout.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/la_capture_readout_if.sv
// Read-port and byte-stream bundle between the capture readout, the capture core and the link TX.
// master: readout side; slave: core/sink side.
interface la_capture_readout_if #(
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned ADDR_WIDTH = 9
);
  logic [ADDR_WIDTH-1:0] read_addr;
  logic [DATA_WIDTH-1:0] read_data;
  logic [7:0]            tx_data;
  logic                  tx_valid;
  logic                  tx_ready;

  modport master (
    output read_addr,
    output tx_data,
    output tx_valid,
    input  read_data,
    input  tx_ready
  );

  modport slave (
    input  read_addr,
    input  tx_data,
    input  tx_valid,
    output read_data,
    output tx_ready
  );
endinterface

// File: rtl/la_capture_readout.sv
// Walks the halted capture ring buffer oldest-first and streams it as a framed byte dump:
// header byte, all samples MSB-first, then an XOR checksum of the sample bytes.
module la_capture_readout #(
  parameter int unsigned DATA_WIDTH   = 128,
  parameter int unsigned ADDR_WIDTH   = 9,
  parameter int unsigned READ_LATENCY = 1,
  parameter logic [7:0]  HEADER_BYTE  = 8'hA5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic                  capture_done_i,
  input  logic [ADDR_WIDTH-1:0] window_start_i,
  output logic                  busy_o,
  output logic                  done_o,
  la_capture_readout_if.master  bus_if
);

  localparam int unsigned BytesPerWord = DATA_WIDTH / 8;
  localparam int unsigned ByteCntW     = (BytesPerWord > 1) ? $clog2(BytesPerWord) : 1;
  localparam int unsigned LastWord     = (2 ** ADDR_WIDTH) - 1;

  typedef enum logic [2:0] {
    StIdle,
    StHeader,
    StAddr,
    StWait,
    StSend,
    StTrailer
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   read_addr_q, read_addr_d;
  logic [ADDR_WIDTH:0]     word_idx_q, word_idx_d;
  logic [ByteCntW-1:0]     byte_cnt_q, byte_cnt_d;
  logic [2:0]              wait_cnt_q, wait_cnt_d;
  logic [DATA_WIDTH-1:0]   shreg_q, shreg_d;
  logic [7:0]              csum_q, csum_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [7:0]              tx_data;
  logic                    tx_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      read_addr_q <= '0;
      word_idx_q  <= '0;
      byte_cnt_q  <= '0;
      wait_cnt_q  <= '0;
      shreg_q     <= '0;
      csum_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      read_addr_q <= read_addr_d;
      word_idx_q  <= word_idx_d;
      byte_cnt_q  <= byte_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      shreg_q     <= shreg_d;
      csum_q      <= csum_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    read_addr_d = read_addr_q;
    word_idx_d  = word_idx_q;
    byte_cnt_d  = byte_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    shreg_d     = shreg_q;
    csum_d      = csum_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    tx_data     = 8'h00;
    tx_valid    = 1'b0;

    unique case (state_q)
      StIdle: begin
        // The done cycle still belongs to the finished dump, so a start landing on it is dropped.
        if (start_i && capture_done_i && !done_q) begin
          read_addr_d = window_start_i;
          word_idx_d  = '0;
          byte_cnt_d  = '0;
          csum_d      = 8'h00;
          busy_d      = 1'b1;
          state_d     = StHeader;
        end
      end

      StHeader: begin
        tx_valid = 1'b1;
        tx_data  = HEADER_BYTE;
        if (bus_if.tx_ready) begin
          state_d = StAddr;
        end
      end

      StAddr: begin
        wait_cnt_d = 3'(READ_LATENCY);
        state_d    = StWait;
      end

      StWait: begin
        wait_cnt_d = wait_cnt_q - 3'd1;
        if (wait_cnt_q == 3'd1) begin
          shreg_d = bus_if.read_data;
          state_d = StSend;
        end
      end

      StSend: begin
        tx_valid = 1'b1;
        tx_data  = shreg_q[DATA_WIDTH-1 -: 8];
        if (bus_if.tx_ready) begin
          csum_d  = csum_q ^ tx_data;
          shreg_d = shreg_q << 8;
          if (byte_cnt_q == ByteCntW'(BytesPerWord - 1)) begin
            byte_cnt_d = '0;
            if (word_idx_q == (ADDR_WIDTH + 1)'(LastWord)) begin
              state_d = StTrailer;
            end else begin
              // Running pointer equals window start + word index, wrapping at the buffer end.
              word_idx_d  = word_idx_q + 1'b1;
              read_addr_d = read_addr_q + 1'b1;
              state_d     = StAddr;
            end
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
          end
        end
      end

      StTrailer: begin
        tx_valid = 1'b1;
        tx_data  = csum_q;
        if (bus_if.tx_ready) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign bus_if.read_addr = read_addr_q;
  assign bus_if.tx_data   = tx_data;
  assign bus_if.tx_valid  = tx_valid;
  assign busy_o           = busy_q;
  assign done_o           = done_q;

endmodule

// File: tb/tb_la_capture_readout.sv
// Drives two readout instances (read latency 1 and 3) from one ring-buffer model and checks
// every transferred byte, the read address and the hold rule against a frame built from the buffer.
module tb_la_capture_readout;

  localparam int DW    = 128;
  localparam int AW    = 9;
  localparam int DEPTH = 512;
  localparam int BPW   = DW / 8;
  localparam int FRAME = 1 + DEPTH * BPW + 1;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          capture_done;
  logic [AW-1:0] win_start;
  logic          tx_ready;
  logic          bp_en;
  logic          busy0, busy1, done0, done1;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] pipe0;
  logic [DW-1:0] pipe1 [3];

  la_capture_readout_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus0 ();
  la_capture_readout_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus1 ();

  la_capture_readout #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(1)) u_dut0 (
    .clk            (clk),
    .rst_n          (rst_n),
    .start_i        (start),
    .capture_done_i (capture_done),
    .window_start_i (win_start),
    .busy_o         (busy0),
    .done_o         (done0),
    .bus_if         (bus0)
  );

  la_capture_readout #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(3)) u_dut1 (
    .clk            (clk),
    .rst_n          (rst_n),
    .start_i        (start),
    .capture_done_i (capture_done),
    .window_start_i (win_start),
    .busy_o         (busy1),
    .done_o         (done1),
    .bus_if         (bus1)
  );

  // Capture core read ports: data appears READ_LATENCY clocks after the address.
  always @(posedge clk) begin
    pipe0    <= mem[bus0.read_addr];
    pipe1[0] <= mem[bus1.read_addr];
    pipe1[1] <= pipe1[0];
    pipe1[2] <= pipe1[1];
  end
  assign bus0.read_data = pipe0;
  assign bus1.read_data = pipe1[2];
  assign bus0.tx_ready  = tx_ready;
  assign bus1.tx_ready  = tx_ready;

  logic          vld [2];
  logic [7:0]    dat [2];
  logic [AW-1:0] ra  [2];
  logic          bsy [2];
  logic          dn  [2];
  assign vld[0] = bus0.tx_valid;  assign vld[1] = bus1.tx_valid;
  assign dat[0] = bus0.tx_data;   assign dat[1] = bus1.tx_data;
  assign ra[0]  = bus0.read_addr; assign ra[1]  = bus1.read_addr;
  assign bsy[0] = busy0;          assign bsy[1] = busy1;
  assign dn[0]  = done0;          assign dn[1]  = done1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input longint act, input longint expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, expv, $time);
    end
  endtask

  // Reference frame: header, every sample oldest-first MSB-first, XOR of the sample bytes.
  logic [7:0] exp_b [FRAME];
  int         ws;

  task automatic build_exp(input int wstart);
    logic [7:0] cs;
    logic [7:0] b;
    logic [DW-1:0] word;
    ws       = wstart;
    exp_b[0] = 8'hA5;
    cs       = 8'h00;
    for (int w = 0; w < DEPTH; w++) begin
      word = mem[(wstart + w) % DEPTH];
      for (int k = 0; k < BPW; k++) begin
        b = word[DW-1-8*k -: 8];
        exp_b[1 + w*BPW + k] = b;
        cs ^= b;
      end
    end
    exp_b[FRAME-1] = cs;
  endtask

  int         idx    [2];
  int         frames [2];
  logic       pv     [2];
  logic [7:0] pd     [2];
  logic [7:0] b1     [2];
  logic [7:0] last   [2];
  logic       pr;

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        idx[i] = 0;
        pv[i]  = 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (pv[i] && !pr) begin
          chk($sformatf("hold_valid%0d", i), vld[i], 1);
          chk($sformatf("hold_data%0d", i), dat[i], pd[i]);
        end
        if (dn[i]) begin
          chk($sformatf("frame_len%0d", i), idx[i], FRAME);
          frames[i]++;
          idx[i] = 0;
        end
        if (vld[i] && tx_ready) begin
          if (idx[i] < FRAME) begin
            chk($sformatf("byte%0d[%0d]", i, idx[i]), dat[i], exp_b[idx[i]]);
            if (idx[i] >= 1 && idx[i] <= FRAME - 2)
              chk($sformatf("read_addr%0d", i), ra[i], (ws + (idx[i] - 1) / BPW) % DEPTH);
          end else begin
            chk($sformatf("overrun%0d", i), idx[i], FRAME - 1);
          end
          if (idx[i] == 1) b1[i] = dat[i];
          last[i] = dat[i];
          idx[i]++;
        end
        pv[i] = vld[i];
        pd[i] = dat[i];
      end
    end
    pr = tx_ready;
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      tx_ready = bp_en ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_frames(input int t0, input int t1);
    for (int c = 0; c < 40000; c++) begin
      if (frames[0] >= t0 && frames[1] >= t1) break;
      @(negedge clk);
    end
    chk("frames_reached0", frames[0], t0);
    chk("frames_reached1", frames[1], t1);
  endtask

  task automatic fill_pattern();
    for (int i = 0; i < DEPTH; i++) mem[i] = {BPW{8'(i)}};
  endtask

  task automatic fill_random();
    for (int i = 0; i < DEPTH; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
  endtask

  int f0, f1;

  initial begin
    rst_n        = 1'b0;
    start        = 1'b0;
    capture_done = 1'b0;
    win_start    = '0;
    bp_en        = 1'b0;
    pr           = 1'b1;
    for (int i = 0; i < 2; i++) begin
      frames[i] = 0;
      idx[i]    = 0;
      pv[i]     = 1'b0;
      b1[i]     = 8'hxx;
      last[i]   = 8'hxx;
    end
    fill_pattern();
    build_exp(0);
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_read_addr", ra[i], 0);
      chk("rst_tx_valid", vld[i], 0);
      chk("rst_tx_data", dat[i], 0);
      chk("rst_busy", bsy[i], 0);
      chk("rst_done", dn[i], 0);
    end
    @(posedge clk); #1 rst_n = 1'b1;

    // start without a halted capture core is ignored
    pulse_start();
    repeat (3) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        chk("gate_busy", bsy[i], 0);
        chk("gate_valid", vld[i], 0);
      end
    end

    // basic dump of the {16{i}} pattern from address 0
    capture_done = 1'b1;
    pulse_start();
    wait_frames(1, 1);
    chk("exp_trailer_basic", exp_b[FRAME-1], 8'h00);
    for (int i = 0; i < 2; i++) begin
      chk("basic_first_data", b1[i], 8'h00);
      chk("basic_trailer", last[i], 8'h00);
    end

    // wrapped window; also a start landing on dut0's done cycle must be dropped
    @(posedge clk); #1 win_start = 9'h1F0;
    build_exp(32'h1F0);
    pulse_start();
    for (int c = 0; c < 20000 && !dn[0]; c++) @(negedge clk);
    chk("wrap_done0_seen", dn[0], 1);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(negedge clk);
    chk("done_start_ignored", bsy[0], 0);
    wait_frames(2, 2);
    for (int i = 0; i < 2; i++) begin
      chk("wrap_first_data", b1[i], 8'hF0);
      chk("wrap_trailer", last[i], 8'h00);
    end

    // random data under backpressure, a stray start and capture_done dropping mid-dump
    fill_random();
    @(posedge clk); #1 win_start = AW'($urandom);
    build_exp(int'(win_start));
    bp_en = 1'b1;
    pulse_start();
    repeat (50) @(posedge clk);
    pulse_start();
    repeat (200) @(posedge clk);
    #1 capture_done = 1'b0;
    wait_frames(3, 3);
    for (int i = 0; i < 2; i++) chk("bp_busy_after", bsy[i], 0);
    bp_en = 1'b0;
    capture_done = 1'b1;

    // reset after 100 transfers, then a fresh complete frame
    fill_random();
    @(posedge clk); #1 win_start = AW'($urandom);
    build_exp(int'(win_start));
    pulse_start();
    for (int c = 0; c < 2000 && idx[0] < 100; c++) @(negedge clk);
    chk("reached_100", idx[0] >= 100, 1);
    f0 = frames[0];
    f1 = frames[1];
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("midrst_valid", vld[i], 0);
      chk("midrst_busy", bsy[i], 0);
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("midrst_no_done0", frames[0], f0);
    chk("midrst_no_done1", frames[1], f1);
    pulse_start();
    wait_frames(f0 + 1, f1 + 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
